// File: rtl/pcu.sv
`default_nettype none
// ============================================================================
//  Module   : pcu
//  Brief    : Program-counter unit for the multi-cycle NPC core. Issues a
//             one-cycle fetch pulse to the IFU, waits for the WBU retire
//             pulse, then steps to pc+4 or to an EXU redirect target.
//             A retired ebreak stops fetching until reset.
//  Options  : PCU_MISALIGN_CHECK_EN - when defined, a misaligned redirect
//             halts the core and raises the misalign output; otherwise the
//             low two target bits are cleared and fetching continues.
//  Revision : 1.0 - initial release
// ============================================================================
module pcu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_next,
    output logic             ifu_receive_valid,
    output logic             halted,
    output logic             spurious_wb,
`ifdef PCU_MISALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        c_ST_BOOT = 2'd0,
        c_ST_WAIT = 2'd1,
        c_ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0]      c_PC_STEP    = 32'd4;
    localparam logic [31:0]      c_ALIGN_MASK = 32'h0000_0003;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state_q;
    logic [31:0]       r_pc_q;
    logic [31:0]       r_pc_next_q;
    logic              r_fetch_q;
    logic              r_halted_q;
    logic              r_spurious_q;
    logic [CNT_W-1:0]  r_cnt_q;

    state_t            w_state_d;
    logic [31:0]       w_pc_d;
    logic [31:0]       w_pc_next_d;
    logic              w_fetch_d;
    logic              w_halted_d;
    logic              w_spurious_d;
    logic [CNT_W-1:0]  w_cnt_d;

    // Redirect target with the byte-offset bits cleared; sequential successor.
    logic [31:0]       w_redirect_tgt;
    logic [31:0]       w_seq_pc;
    logic              w_misaligned;

    assign w_redirect_tgt = redirect_pc & ~c_ALIGN_MASK;
    assign w_seq_pc       = r_pc_q + c_PC_STEP;
    assign w_misaligned   = (redirect_pc[1:0] != 2'b00);

`ifdef PCU_MISALIGN_CHECK_EN
    logic r_misalign_q;
    logic w_misalign_d;
`endif

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_pc_next_d  = r_pc_next_q;
        w_fetch_d    = 1'b0;
        w_halted_d   = r_halted_q;
        w_spurious_d = r_spurious_q;
        w_cnt_d      = r_cnt_q;
`ifdef PCU_MISALIGN_CHECK_EN
        w_misalign_d = r_misalign_q;
`endif

        case (r_state_q)
            c_ST_BOOT: begin
                // First fetch goes out at RESET_PC, already held in pc_next.
                w_fetch_d = 1'b1;
                w_state_d = c_ST_WAIT;
                if (wb_valid) begin
                    w_spurious_d = 1'b1;
                end
            end

            c_ST_WAIT: begin
                if (wb_valid) begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                    if (halt) begin
                        // ebreak wins over any redirect retiring with it.
                        w_state_d  = c_ST_HALT;
                        w_halted_d = 1'b1;
                    end else if (redirect_valid) begin
`ifdef PCU_MISALIGN_CHECK_EN
                        if (w_misaligned) begin
                            // Keep the offending target visible for debug.
                            w_state_d    = c_ST_HALT;
                            w_halted_d   = 1'b1;
                            w_misalign_d = 1'b1;
                            w_pc_d       = redirect_pc;
                        end else begin
                            w_pc_d      = w_redirect_tgt;
                            w_pc_next_d = w_redirect_tgt;
                            w_fetch_d   = 1'b1;
                        end
`else
                        w_pc_d      = w_redirect_tgt;
                        w_pc_next_d = w_redirect_tgt;
                        w_fetch_d   = 1'b1;
`endif
                    end else begin
                        w_pc_d      = w_seq_pc;
                        w_pc_next_d = w_seq_pc;
                        w_fetch_d   = 1'b1;
                    end
                end
            end

            c_ST_HALT: begin
                // Absorbing; a retire here is only flagged.
                if (wb_valid) begin
                    w_spurious_d = 1'b1;
                end
            end

            default: begin
                w_state_d = c_ST_BOOT;
            end
        endcase
    end

`ifndef PCU_MISALIGN_CHECK_EN
    // Only consumed when the misalign check is built in.
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_misaligned;
`endif

    // State and registered outputs; reset restarts the boot sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_BOOT;
            r_pc_q       <= RESET_PC;
            r_pc_next_q  <= RESET_PC;
            r_fetch_q    <= 1'b0;
            r_halted_q   <= 1'b0;
            r_spurious_q <= 1'b0;
            r_cnt_q      <= '0;
`ifdef PCU_MISALIGN_CHECK_EN
            r_misalign_q <= 1'b0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_pc_q       <= w_pc_d;
            r_pc_next_q  <= w_pc_next_d;
            r_fetch_q    <= w_fetch_d;
            r_halted_q   <= w_halted_d;
            r_spurious_q <= w_spurious_d;
            r_cnt_q      <= w_cnt_d;
`ifdef PCU_MISALIGN_CHECK_EN
            r_misalign_q <= w_misalign_d;
`endif
        end
    end

    assign pc                = r_pc_q;
    assign pc_next           = r_pc_next_q;
    assign ifu_receive_valid = r_fetch_q;
    assign halted            = r_halted_q;
    assign spurious_wb       = r_spurious_q;
    assign retire_cnt        = r_cnt_q;
`ifdef PCU_MISALIGN_CHECK_EN
    assign misalign          = r_misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcu
//  Brief    : Self-checking bench for pcu. Stimulus pushes the expected
//             fetch (address and cycle) into a queue; a monitor pops and
//             compares on every ifu_receive_valid pulse. Status outputs are
//             compared directly against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned CNT_W    = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_valid;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             halt;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic             ifu_receive_valid;
    logic             halted;
    logic             spurious_wb;
    logic [CNT_W-1:0] retire_cnt;
`ifdef PCU_MISALIGN_CHECK_EN
    logic             misalign;
`endif

    pcu #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .wb_valid          (wb_valid),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt              (halt),
        .pc                (pc),
        .pc_next           (pc_next),
        .ifu_receive_valid (ifu_receive_valid),
        .halted            (halted),
        .spurious_wb       (spurious_wb),
`ifdef PCU_MISALIGN_CHECK_EN
        .misalign          (misalign),
`endif
        .retire_cnt        (retire_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every fetch pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ifu_receive_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got ifu_receive_valid=%b pc_next=%h expected no pulse (cycle %0d)",
                         ifu_receive_valid, pc_next, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_pc_next", {32'd0, pc_next}, {32'd0, mon_e.addr});
                check("pulse_pc",      {32'd0, pc},      {32'd0, mon_e.addr});
                check("pulse_cycle",   {32'd0, cyc},     {32'd0, mon_e.cyc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
    endtask

    task automatic expect_fetch(input logic [31:0] addr);
        exp_q.push_back('{addr: addr, cyc: cyc + 1});
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Hold reset for three edges, release, expect the boot fetch.
    task automatic do_reset(input logic verify);
        idle_inputs();
        rst = 1'b1;
        tick();
        if (verify) begin
            check("rst_pc",       {32'd0, pc},      {32'd0, RESET_PC});
            check("rst_pc_next",  {32'd0, pc_next}, {32'd0, RESET_PC});
            check("rst_ifu",      {63'd0, ifu_receive_valid}, 64'd0);
            check("rst_halted",   {63'd0, halted},      64'd0);
            check("rst_spurious", {63'd0, spurious_wb}, 64'd0);
            check("rst_cnt",      retire_cnt,           64'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        expect_fetch(RESET_PC);
    endtask

    // One accepted-or-not retire pulse lasting a single cycle.
    task automatic retire(input logic redir, input logic [31:0] rpc, input logic h,
                          input logic pulse, input logic [31:0] exp_addr);
        wb_valid       = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        halt           = h;
        if (pulse) expect_fetch(exp_addr);
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;

        // T1: reset values and boot fetch
        do_reset(1'b1);
        repeat (5) tick();
        check_drained("t1_boot_pulse");

        // T2: three sequential retires, five cycles apart
        retire(1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0004); repeat (4) tick();
        retire(1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0008); repeat (4) tick();
        retire(1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_000C); repeat (4) tick();
        check("t2_cnt", retire_cnt, 64'd3);
        check("t2_pc_hold", {32'd0, pc}, 64'h8000_000C);
        check_drained("t2_pulses");

        // T3: redirect then sequential from the new target (back-to-back)
        retire(1'b1, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0100);
        retire(1'b0, 32'd0,         1'b0, 1'b1, 32'h8000_0104);
        repeat (3) tick();
        check("t3_cnt", retire_cnt, 64'd5);
        check_drained("t3_pulses");

        // T4: halt beats redirect; later retires are spurious
        retire(1'b1, 32'h8000_0200, 1'b1, 1'b0, 32'd0);
        check("t4_halted_t1", {63'd0, halted}, 64'd1);
        check("t4_pc",        {32'd0, pc},      64'h8000_0104);
        check("t4_pc_next",   {32'd0, pc_next}, 64'h8000_0104);
        check("t4_spur_pre",  {63'd0, spurious_wb}, 64'd0);
        check("t4_cnt",       retire_cnt, 64'd6);
        repeat (2) tick();
        retire(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        check("t4_spur_post", {63'd0, spurious_wb}, 64'd1);
        check("t4_cnt_hold",  retire_cnt, 64'd6);
        check("t4_halted",    {63'd0, halted}, 64'd1);
        check("t4_pc_frozen", {32'd0, pc}, 64'h8000_0104);
        check_drained("t4_no_pulse");

        // T5: 32-bit wrap of the sequential step
        do_reset(1'b0);
        repeat (3) tick();
        retire(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC); repeat (2) tick();
        retire(1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_0000); repeat (2) tick();
        check("t5_wrap_pc", {32'd0, pc}, 64'd0);
        check("t5_cnt",     retire_cnt,  64'd2);
        check_drained("t5_pulses");

        // T6: reset in WAIT with a retire on the same edge
        wb_valid = 1'b1;
        rst      = 1'b1;
        tick();
        check("t6_ifu",     {63'd0, ifu_receive_valid}, 64'd0);
        check("t6_pc",      {32'd0, pc},      {32'd0, RESET_PC});
        check("t6_pc_next", {32'd0, pc_next}, {32'd0, RESET_PC});
        check("t6_cnt",     retire_cnt, 64'd0);
        idle_inputs();
        tick();
        rst      = 1'b0;
        wb_valid = 1'b1;       // lands in the BOOT cycle
        expect_fetch(RESET_PC);
        tick();
        idle_inputs();
        check("t6_boot_spur", {63'd0, spurious_wb}, 64'd1);
        check("t6_boot_cnt",  retire_cnt, 64'd0);
        repeat (3) tick();
        check_drained("t6_reboot_pulse");

        // T5 (cont.): misaligned redirect
`ifdef PCU_MISALIGN_CHECK_EN
        retire(1'b1, 32'h8000_0102, 1'b0, 1'b0, 32'd0);
        check("t5_misalign",  {63'd0, misalign}, 64'd1);
        check("t5_mis_halt",  {63'd0, halted},   64'd1);
        check("t5_mis_pc",    {32'd0, pc},       64'h8000_0102);
`else
        retire(1'b1, 32'h8000_0102, 1'b0, 1'b1, 32'h8000_0100);
        check("t5_mask_halt", {63'd0, halted}, 64'd0);
`endif
        repeat (4) tick();
        check("t5_mis_cnt", retire_cnt, 64'd1);
        check_drained("t5_misalign_pulses");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
